// File: rtl/const_mult_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | const_mult_sched                                                         |
// | Round-robin, credit-based scheduler sharing one fixed-latency constant   |
// | multiplier between two requesters, with per-requester response FIFOs.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module const_mult_sched #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [23:0] req_a24_0,
  input  logic [23:0] req_a24_1,
  input  logic [24:0] req_a25_0,
  input  logic [24:0] req_a25_1,
  output logic [23:0] mul_a_24,
  output logic [24:0] mul_a_25,
  output logic        mul_din_flag,
  input  logic [47:0] mul_d_24,
  input  logic [43:0] mul_d_25,
  input  logic        mul_dout_flag,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [47:0] resp_d24_0,
  output logic [47:0] resp_d24_1,
  output logic [43:0] resp_d25_0,
  output logic [43:0] resp_d25_1,
  output logic        busy,
  output logic        err
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH) + 1;
  localparam int c_BW = $clog2(LAT + 1);
  localparam int c_DW = 92;

  logic [c_CW-1:0] r_credit [2];
  logic            r_last;
  logic [23:0]     r_mul_a24;
  logic [24:0]     r_mul_a25;
  logic            r_din;
  logic [LAT:0]    r_tag_v;
  logic [LAT:0]    r_tag_id;
  logic [c_BW-1:0] r_blank;
  logic            r_err;
  logic [c_DW-1:0] r_mem [2][DEPTH];
  logic [c_AW-1:0] r_wp [2];
  logic [c_AW-1:0] r_rp [2];
  logic [c_CW-1:0] r_cnt [2];

  logic [1:0]      w_elig;
  logic [1:0]      w_grant;
  logic [1:0]      w_resp_valid;
  logic [1:0]      w_pop;
  logic [1:0]      w_wr_sel;
  logic            w_live;
  logic            w_wr;
  logic            w_err_ev;
  logic [c_DW-1:0] w_head0;
  logic [c_DW-1:0] w_head1;

  always_comb begin
    w_elig       = '0;
    w_resp_valid = '0;
    for (int i = 0; i < 2; i++) begin
      w_elig[i]       = req_valid[i] && (r_credit[i] != '0) && !rst;
      w_resp_valid[i] = (r_cnt[i] != '0) && !rst;
    end
    // r_last holds the most recent grant; the other requester wins a tie
    w_grant[0] = w_elig[0] && (!w_elig[1] || r_last);
    w_grant[1] = w_elig[1] && (!w_elig[0] || !r_last);
    w_pop      = w_resp_valid & resp_ready;
  end

  // Results arriving while the blanking counter runs come from a multiplier
  // pipeline that was never reset, so they are neither stored nor flagged.
  assign w_live   = (r_blank == '0);
  assign w_wr     = mul_dout_flag && r_tag_v[LAT] && w_live;
  assign w_wr_sel = {w_wr && r_tag_id[LAT], w_wr && !r_tag_id[LAT]};
  assign w_err_ev = w_live && (mul_dout_flag != r_tag_v[LAT]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_credit[i] <= c_CW'(DEPTH);
        r_wp[i]     <= '0;
        r_rp[i]     <= '0;
        r_cnt[i]    <= '0;
      end
      r_last   <= 1'b1;
      r_din    <= 1'b0;
      r_tag_v  <= '0;
      r_tag_id <= '0;
      r_blank  <= c_BW'(LAT);
      r_err    <= 1'b0;
    end else begin
      if (!w_live) begin
        r_blank <= r_blank - c_BW'(1);
      end
      if (|w_grant) begin
        r_last    <= w_grant[1];
        r_mul_a24 <= w_grant[1] ? req_a24_1 : req_a24_0;
        r_mul_a25 <= w_grant[1] ? req_a25_1 : req_a25_0;
      end
      r_din    <= |w_grant;
      r_tag_v  <= {r_tag_v[LAT-1:0], |w_grant};
      r_tag_id <= {r_tag_id[LAT-1:0], w_grant[1]};
      r_err    <= r_err || w_err_ev;
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i] && !w_pop[i]) begin
          r_credit[i] <= r_credit[i] - c_CW'(1);
        end else if (!w_grant[i] && w_pop[i]) begin
          r_credit[i] <= r_credit[i] + c_CW'(1);
        end
        if (w_wr_sel[i]) begin
          r_mem[i][r_wp[i]] <= {mul_d_24, mul_d_25};
          r_wp[i]           <= r_wp[i] + c_AW'(1);
        end
        if (w_pop[i]) begin
          r_rp[i] <= r_rp[i] + c_AW'(1);
        end
        r_cnt[i] <= r_cnt[i] + c_CW'(w_wr_sel[i]) - c_CW'(w_pop[i]);
      end
    end
  end

  assign w_head0 = r_mem[0][r_rp[0]];
  assign w_head1 = r_mem[1][r_rp[1]];

  assign req_ready    = w_grant;
  assign resp_valid   = w_resp_valid;
  assign mul_a_24     = r_mul_a24;
  assign mul_a_25     = r_mul_a25;
  assign mul_din_flag = r_din && !rst;
  assign err          = r_err && !rst;
  assign busy         = !rst && ((|r_tag_v) || (r_cnt[0] != '0) || (r_cnt[1] != '0) || r_din);
  assign resp_d24_0   = w_head0[91:44];
  assign resp_d25_0   = w_head0[43:0];
  assign resp_d24_1   = w_head1[91:44];
  assign resp_d25_1   = w_head1[43:0];

endmodule
`default_nettype wire

// File: tb/tb_const_mult_sched.sv
`default_nettype none
// Bench for const_mult_sched: directed scenarios plus random traffic, checked
// against a queue-based model of credits, arbitration and response latency.
module tb_const_mult_sched;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 4;
  localparam logic [23:0] K24   = 24'hB504F3;
  localparam logic [18:0] K25   = 19'd512065;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [23:0] req_a24_0, req_a24_1, mul_a_24;
  logic [24:0] req_a25_0, req_a25_1, mul_a_25;
  logic        mul_din_flag, mul_dout_flag, busy, err, spur;
  logic [47:0] mul_d_24, resp_d24_0, resp_d24_1;
  logic [43:0] mul_d_25, resp_d25_0, resp_d25_1;

  always #5 clk = ~clk;

  const_mult_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a24_0(req_a24_0), .req_a24_1(req_a24_1),
    .req_a25_0(req_a25_0), .req_a25_1(req_a25_1),
    .mul_a_24(mul_a_24), .mul_a_25(mul_a_25), .mul_din_flag(mul_din_flag),
    .mul_d_24(mul_d_24), .mul_d_25(mul_d_25), .mul_dout_flag(mul_dout_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_d24_0(resp_d24_0), .resp_d24_1(resp_d24_1),
    .resp_d25_0(resp_d25_0), .resp_d25_1(resp_d25_1),
    .busy(busy), .err(err)
  );

  // Constant multiplier with LAT cycles of latency and no reset
  logic        pf  [LAT];
  logic [47:0] p24 [LAT];
  logic [43:0] p25 [LAT];
  always_ff @(posedge clk) begin
    pf[0]  <= mul_din_flag;
    p24[0] <= 48'(mul_a_24) * 48'(K24);
    p25[0] <= 44'(mul_a_25) * 44'(K25);
    for (int k = 1; k < LAT; k++) begin
      pf[k]  <= pf[k-1];
      p24[k] <= p24[k-1];
      p25[k] <= p25[k-1];
    end
  end
  assign mul_dout_flag = pf[LAT-1] | spur;
  assign mul_d_24      = p24[LAT-1];
  assign mul_d_25      = p25[LAT-1];

  typedef struct {
    logic [47:0] d24;
    logic [43:0] d25;
    int          rdy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   m_credit [2];
  int   m_last;
  bit   m_din;
  bit   err_exp;
  int   cyc, n_vec, n_err;
  int   d_acc [2];
  int   d_pop [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic rnd_data();
    req_a24_0 = 24'($urandom);
    req_a24_1 = 24'($urandom);
    req_a25_0 = 25'($urandom);
    req_a25_1 = 25'($urandom);
  endtask

  // Inputs are set just after a falling edge; this checks, updates the model
  // and advances to the next falling edge.
  task automatic cycle();
    bit   e0, e1, g0, g1, rv0, rv1;
    exp_t e;
    #1;
    d_acc[0] += int'(req_ready[0]);
    d_acc[1] += int'(req_ready[1]);
    d_pop[0] += int'(resp_valid[0] & resp_ready[0]);
    d_pop[1] += int'(resp_valid[1] & resp_ready[1]);
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_din_flag", 64'(mul_din_flag), 64'(0));
      q0.delete();
      q1.delete();
      m_credit[0] = DEPTH;
      m_credit[1] = DEPTH;
      m_last  = 1;
      m_din   = 1'b0;
      err_exp = 1'b0;
    end else begin
      e0 = req_valid[0] && (m_credit[0] > 0);
      e1 = req_valid[1] && (m_credit[1] > 0);
      if (e0 && e1) begin
        g0 = (m_last == 1);
        g1 = !g0;
      end else begin
        g0 = e0;
        g1 = e1;
      end
      rv0 = 1'b0;
      rv1 = 1'b0;
      if (q0.size() > 0) rv0 = (q0[0].rdy <= cyc);
      if (q1.size() > 0) rv1 = (q1[0].rdy <= cyc);
      chk("req_ready", 64'(req_ready), 64'({g1, g0}));
      chk("resp_valid", 64'(resp_valid), 64'({rv1, rv0}));
      chk("busy", 64'(busy), 64'((q0.size() + q1.size()) != 0));
      chk("err", 64'(err), 64'(err_exp));
      chk("din_flag", 64'(mul_din_flag), 64'(m_din));
      if (rv0 && resp_ready[0]) begin
        e = q0.pop_front();
        chk("resp0_d24", 64'(resp_d24_0), 64'(e.d24));
        chk("resp0_d25", 64'(resp_d25_0), 64'(e.d25));
        m_credit[0]++;
      end
      if (rv1 && resp_ready[1]) begin
        e = q1.pop_front();
        chk("resp1_d24", 64'(resp_d24_1), 64'(e.d24));
        chk("resp1_d25", 64'(resp_d25_1), 64'(e.d25));
        m_credit[1]++;
      end
      if (g0) begin
        e.d24 = 48'(req_a24_0) * 48'(K24);
        e.d25 = 44'(req_a25_0) * 44'(K25);
        e.rdy = cyc + 2 + LAT;
        q0.push_back(e);
        m_credit[0]--;
        m_last = 0;
      end
      if (g1) begin
        e.d24 = 48'(req_a24_1) * 48'(K24);
        e.d25 = 44'(req_a25_1) * 44'(K25);
        e.rdy = cyc + 2 + LAT;
        q1.push_back(e);
        m_credit[1]--;
        m_last = 1;
      end
      m_din = g0 || g1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    repeat (n) cycle();
  endtask

  initial begin
    int a0, a1, p0, p1;
    n_vec = 0; n_err = 0; cyc = 0;
    d_acc[0] = 0; d_acc[1] = 0; d_pop[0] = 0; d_pop[1] = 0;
    rst = 1'b1; spur = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    rnd_data();
    @(negedge clk);
    cycle();
    cycle();

    // Single request: operand 1 returns the constant itself after 4 cycles
    rst = 1'b0;
    req_valid = 2'b01; req_a25_0 = 25'd1; req_a24_0 = 24'd3; resp_ready = 2'b11;
    cycle();
    req_valid = 2'b00;
    repeat (3) cycle();
    #1;
    chk("single_rv", 64'(resp_valid), 64'(1));
    chk("single_d25", 64'(resp_d25_0), 64'(512065));
    cycle();
    repeat (2) cycle();
    a0 = d_acc[0];
    resp_ready = 2'b00; req_valid = 2'b01;
    repeat (6) begin rnd_data(); cycle(); end
    chk("single_credit_full", 64'(d_acc[0] - a0), 64'(4));
    drain(10);

    // Contention: strict alternation starting with requester 0
    do_reset();
    p0 = d_pop[0]; p1 = d_pop[1];
    resp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      rnd_data();
      #1 chk("contend_grant", 64'(req_ready), (i % 2 == 1) ? 64'(2) : 64'(1));
      cycle();
    end
    drain(10);
    chk("contend_resp0", 64'(d_pop[0] - p0), 64'(3));
    chk("contend_resp1", 64'(d_pop[1] - p1), 64'(3));

    // Backpressure on requester 1
    a1 = d_acc[1];
    resp_ready = 2'b01; req_valid = 2'b11;
    repeat (12) begin rnd_data(); cycle(); end
    chk("bp_accepts", 64'(d_acc[1] - a1), 64'(4));
    req_valid = 2'b00; resp_ready = 2'b11;
    cycle();
    a1 = d_acc[1];
    resp_ready = 2'b01; req_valid = 2'b10;
    repeat (6) begin rnd_data(); cycle(); end
    chk("bp_one_more", 64'(d_acc[1] - a1), 64'(1));
    drain(12);

    // Reset one cycle after two accepts; stale results must be discarded
    do_reset();
    resp_ready = 2'b11; req_valid = 2'b01;
    repeat (2) begin rnd_data(); cycle(); end
    do_reset();
    repeat (6) cycle();
    a0 = d_acc[0];
    resp_ready = 2'b00; req_valid = 2'b01;
    repeat (6) begin rnd_data(); cycle(); end
    chk("midrst_credit_full", 64'(d_acc[0] - a0), 64'(4));
    drain(10);

    // Spurious flag: ignored inside blanking, sticky error afterwards
    do_reset();
    spur = 1'b1;
    cycle();
    spur = 1'b0;
    repeat (3) cycle();
    spur = 1'b1;
    cycle();
    spur = 1'b0;
    err_exp = 1'b1;
    repeat (3) cycle();
    chk("spur_err_held", 64'(err), 64'(1));

    // Full FIFO at zero credit: pop first, accept only on the next cycle
    do_reset();
    resp_ready = 2'b00; req_valid = 2'b01;
    repeat (8) begin rnd_data(); cycle(); end
    resp_ready = 2'b01;
    #1 chk("full_pop_no_accept", 64'(req_ready), 64'(0));
    cycle();
    #1 chk("after_pop_accept", 64'(req_ready), 64'(1));
    cycle();
    for (int i = 0; i < 100; i++) begin
      rnd_data();
      req_valid  = 2'($urandom);
      resp_ready = 2'($urandom);
      cycle();
    end
    drain(16);
    #1 chk("final_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
